// File: rtl/rsi_div_pkg.sv
// Shared types and constants for the restoring divider: the default operand width,
// the FSM state encoding and the iteration counter width.
package rsi_div_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int CNT_W          = $clog2(DEFAULT_DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter width for an arbitrary operand width; it must be able to hold DATA_W itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/rsi_div_operand_slot.sv
// One-deep operand holding slot: captures tdata on a tvalid/tready handshake and
// stays full until the divider loads it.
module rsi_div_operand_slot
  import rsi_div_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              tvalid_i,
  input  logic [DATA_W-1:0] tdata_i,
  input  logic              clr_i,
  output logic              tready_o,
  output logic              full_o,
  output logic [DATA_W-1:0] data_o
);

  logic              full_q, full_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Slot register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  // Clear is only issued while full (tready low), so it never races a capture.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (clr_i) begin
      full_d = 1'b0;
    end else if (tvalid_i && !full_q) begin
      full_d = 1'b1;
      data_d = tdata_i;
    end else begin
      full_d = full_q;
      data_d = data_q;
    end
  end

  assign tready_o = !full_q;
  assign full_o   = full_q;
  assign data_o   = data_q;

endmodule

// File: rtl/rsi_divider.sv
// Unsigned restoring divider with AXI-stream operand/result channels and one-deep prefetch.
// Optional divide-by-zero flag on m_axis_dout_tuser when RSI_DIV_BYZERO_FLAG_EN is defined.
module rsi_divider
  import rsi_div_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              s_aclk,
  input  logic              s_aresetn,
  input  logic              s_axis_dividend_tvalid,
  output logic              s_axis_dividend_tready,
  input  logic [DATA_W-1:0] s_axis_dividend_tdata,
  input  logic              s_axis_divisor_tvalid,
  output logic              s_axis_divisor_tready,
  input  logic [DATA_W-1:0] s_axis_divisor_tdata,
  output logic              m_axis_dout_tvalid,
  input  logic              m_axis_dout_tready,
`ifdef RSI_DIV_BYZERO_FLAG_EN
  output logic              m_axis_dout_tuser,
`endif
  output logic [DATA_W-1:0] m_axis_dout_tdata
);

  localparam int CW = cnt_width(DATA_W);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W:0]   rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dsr_q, dsr_d;
  logic              valid_q, valid_d;
  logic              dvd_full_s, dsr_full_s;
  logic [DATA_W-1:0] dvd_data_s, dsr_data_s;
  logic              load_s, step_s, last_s, hs_s;
  logic [DATA_W:0]   rem_sh_s;
  logic [DATA_W+1:0] trial_s;

  rsi_div_operand_slot #(.DATA_W(DATA_W)) u_dividend_slot (
    .clk_i    (s_aclk),
    .rst_ni   (s_aresetn),
    .tvalid_i (s_axis_dividend_tvalid),
    .tdata_i  (s_axis_dividend_tdata),
    .clr_i    (load_s),
    .tready_o (s_axis_dividend_tready),
    .full_o   (dvd_full_s),
    .data_o   (dvd_data_s)
  );

  rsi_div_operand_slot #(.DATA_W(DATA_W)) u_divisor_slot (
    .clk_i    (s_aclk),
    .rst_ni   (s_aresetn),
    .tvalid_i (s_axis_divisor_tvalid),
    .tdata_i  (s_axis_divisor_tdata),
    .clr_i    (load_s),
    .tready_o (s_axis_divisor_tready),
    .full_o   (dsr_full_s),
    .data_o   (dsr_data_s)
  );

  // FSM state register.
  always_ff @(posedge s_aclk) begin
    if (!s_aresetn) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (dvd_full_s && dsr_full_s) state_d = CALC; else state_d = IDLE;
      CALC:    if (last_s) state_d = DONE; else state_d = CALC;
      DONE:    if (m_axis_dout_tready) state_d = IDLE; else state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // FSM control outputs.
  always_comb begin
    load_s = 1'b0;
    step_s = 1'b0;
    hs_s   = 1'b0;
    case (state_q)
      IDLE:    load_s = dvd_full_s && dsr_full_s;
      CALC:    step_s = 1'b1;
      DONE:    hs_s   = valid_q && m_axis_dout_tready;
      default: load_s = 1'b0;
    endcase
    last_s = step_s && (cnt_q == CW'(DATA_W - 1));
  end

  // One restoring step: the dividend shifts out MSB first while quotient bits shift in.
  // The trial subtraction is one bit wider than the remainder so its sign is the borrow.
  assign rem_sh_s = {rem_q[DATA_W-1:0], quo_q[DATA_W-1]};
  assign trial_s  = {1'b0, rem_sh_s} - {2'b00, dsr_q};

  // Datapath next-state logic.
  always_comb begin
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dsr_d   = dsr_q;
    valid_d = valid_q;
    if (load_s) begin
      cnt_d = '0;
      rem_d = '0;
      quo_d = dvd_data_s;
      dsr_d = dsr_data_s;
    end else if (step_s) begin
      cnt_d = cnt_q + CW'(1);
      if (!trial_s[DATA_W+1]) begin
        rem_d = trial_s[DATA_W:0];
        quo_d = {quo_q[DATA_W-2:0], 1'b1};
      end else begin
        rem_d = rem_sh_s;
        quo_d = {quo_q[DATA_W-2:0], 1'b0};
      end
    end else begin
      cnt_d = cnt_q;
    end
    if (last_s)    valid_d = 1'b1;
    else if (hs_s) valid_d = 1'b0;
    else           valid_d = valid_q;
  end

  // Datapath registers.
  always_ff @(posedge s_aclk) begin
    if (!s_aresetn) begin
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dsr_q   <= dsr_d;
      valid_q <= valid_d;
    end
  end

`ifdef RSI_DIV_BYZERO_FLAG_EN
  logic byzero_q;

  // Divide-by-zero flag, captured with the operands and held with the quotient.
  always_ff @(posedge s_aclk) begin
    if (!s_aresetn)  byzero_q <= 1'b0;
    else if (load_s) byzero_q <= (dsr_data_s == '0);
    else             byzero_q <= byzero_q;
  end

  assign m_axis_dout_tuser = byzero_q;
`endif

  assign m_axis_dout_tvalid = valid_q;
  assign m_axis_dout_tdata  = quo_q;

endmodule

// File: tb/tb_rsi_divider.sv
// Directed self-checking bench for rsi_divider (DATA_W = 32): latency, quotients,
// divide-by-zero, prefetch with output backpressure, and mid-calculation reset.
module tb_rsi_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rstn;
  logic         dvd_valid, dsr_valid, dout_ready;
  logic         dvd_ready, dsr_ready, dout_valid;
  logic [W-1:0] dvd_data, dsr_data, dout_data;
`ifdef RSI_DIV_BYZERO_FLAG_EN
  logic         dout_user;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int edge_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  rsi_divider #(.DATA_W(W)) dut (
    .s_aclk                 (clk),
    .s_aresetn              (rstn),
    .s_axis_dividend_tvalid (dvd_valid),
    .s_axis_dividend_tready (dvd_ready),
    .s_axis_dividend_tdata  (dvd_data),
    .s_axis_divisor_tvalid  (dsr_valid),
    .s_axis_divisor_tready  (dsr_ready),
    .s_axis_divisor_tdata   (dsr_data),
    .m_axis_dout_tvalid     (dout_valid),
    .m_axis_dout_tready     (dout_ready),
`ifdef RSI_DIV_BYZERO_FLAG_EN
    .m_axis_dout_tuser      (dout_user),
`endif
    .m_axis_dout_tdata      (dout_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b, output int e);
    dvd_valid = 1'b1; dvd_data = a;
    dsr_valid = 1'b1; dsr_data = b;
    tick();
    e = edge_cnt;
    dvd_valid = 1'b0;
    dsr_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int e);
    e = -1000;
    for (int i = 0; i < budget; i++) begin
      if (dout_valid === 1'b1) begin
        e = edge_cnt;
        break;
      end
      tick();
    end
  endtask

  initial begin
    int e0, e1, h, seen;
    rstn = 1'b0; dvd_valid = 1'b0; dsr_valid = 1'b0; dout_ready = 1'b1;
    dvd_data = '0; dsr_data = '0;
    tick(); tick();
    rstn = 1'b1;
    check("rst_dvd_ready", 32'(dvd_ready), 32'd1);
    check("rst_dsr_ready", 32'(dsr_ready), 32'd1);
    check("rst_tvalid", 32'(dout_valid), 32'd0);
    check("rst_tdata", dout_data, 32'd0);

    // 3700 / 50, both operands on the same edge
    send_pair(32'd3700, 32'd50, e0);
    wait_valid(60, e1);
    check("lat_3700_50", 32'(e1 - e0), 32'd33);
    check("q_3700_50", dout_data, 32'd74);
    tick();
    check("hs_clears_valid", 32'(dout_valid), 32'd0);

    // 100 / 1, divisor three cycles late; full dividend slot ignores new tdata
    dvd_valid = 1'b1; dvd_data = 32'd100;
    tick();
    e0 = edge_cnt;
    dvd_data = 32'd999;
    check("dvd_ready_full0", 32'(dvd_ready), 32'd0);
    tick();
    check("dvd_ready_full1", 32'(dvd_ready), 32'd0);
    tick();
    check("dvd_ready_full2", 32'(dvd_ready), 32'd0);
    dsr_valid = 1'b1; dsr_data = 32'd1;
    tick();
    e0 = edge_cnt;
    dsr_valid = 1'b0; dvd_valid = 1'b0;
    check("dvd_ready_preload", 32'(dvd_ready), 32'd0);
    tick();
    check("dvd_ready_postload", 32'(dvd_ready), 32'd1);
    wait_valid(60, e1);
    check("lat_100_1", 32'(e1 - e0), 32'd33);
    check("q_100_1", dout_data, 32'd100);
    tick();

    // divide by zero, then 5 / 5
    send_pair(32'd5, 32'd0, e0);
    wait_valid(60, e1);
    check("lat_5_0", 32'(e1 - e0), 32'd33);
    check("q_5_0", dout_data, 32'hFFFF_FFFF);
`ifdef RSI_DIV_BYZERO_FLAG_EN
    check("tuser_5_0", 32'(dout_user), 32'd1);
`endif
    tick();
    send_pair(32'd5, 32'd5, e0);
    wait_valid(60, e1);
    check("q_5_5", dout_data, 32'd1);
`ifdef RSI_DIV_BYZERO_FLAG_EN
    check("tuser_5_5", 32'(dout_user), 32'd0);
`endif
    tick();

    // backpressure with a prefetched pair
    dout_ready = 1'b0;
    send_pair(32'd3700, 32'd50, e0);
    tick();
    check("ready_after_load", 32'(dsr_ready), 32'd1);
    send_pair(32'd900, 32'd30, e1);
    wait_valid(60, e1);
    check("lat_bp", 32'(e1 - e0), 32'd33);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_held", 32'(dout_valid), 32'd1);
      check("bp_data_held", dout_data, 32'd74);
      check("bp_dvd_ready", 32'(dvd_ready), 32'd0);
      check("bp_dsr_ready", 32'(dsr_ready), 32'd0);
      tick();
    end
    dout_ready = 1'b1;
    tick();
    h = edge_cnt;
    check("bp_hs_clears", 32'(dout_valid), 32'd0);
    wait_valid(60, e1);
    check("lat_prefetch", 32'(e1 - h), 32'd33);
    check("q_900_30", dout_data, 32'd30);
    tick();
    check("b2b_period", 32'(edge_cnt - h), 32'd34);
    check("b2b_hs_clears", 32'(dout_valid), 32'd0);

    // reset at CALC iteration 10 with a prefetched pair pending
    send_pair(32'd3700, 32'd50, e0);
    tick();
    send_pair(32'd7, 32'd7, e1);
    while (edge_cnt < e0 + 11) tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("abort_dvd_ready", 32'(dvd_ready), 32'd1);
    check("abort_dsr_ready", 32'(dsr_ready), 32'd1);
    check("abort_tdata", dout_data, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (dout_valid !== 1'b0) seen++;
      tick();
    end
    check("abort_no_valid", 32'(seen), 32'd0);
    send_pair(32'd81, 32'd9, e0);
    wait_valid(60, e1);
    check("lat_81_9", 32'(e1 - e0), 32'd33);
    check("q_81_9", dout_data, 32'd9);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rsi_divider.md
RSI_DIVIDER -- requirements
Module: rsi_divider

Interface
REQ-001 SHALL have parameter DATA_W, default 32, giving the operand and quotient width in bits.
REQ-002 SHALL have these ports; clock and reset are listed first:
  s_aclk  in  1  single clock; all logic on its rising edge
  s_aresetn  in  1  reset; synchronous and active-low
  s_axis_dividend_tvalid  in  1  dividend offered
  s_axis_dividend_tready  out  1  dividend slot empty
  s_axis_dividend_tdata  in  DATA_W  unsigned dividend
  s_axis_divisor_tvalid  in  1  divisor offered
  s_axis_divisor_tready  out  1  divisor slot empty
  s_axis_divisor_tdata  in  DATA_W  unsigned divisor
  m_axis_dout_tvalid  out  1  quotient valid
  m_axis_dout_tready  in  1  consumer accepts quotient
  m_axis_dout_tdata  out  DATA_W  unsigned quotient
  m_axis_dout_tuser  out  1  divide-by-zero flag; present only with RSI_DIV_BYZERO_FLAG_EN

Function
REQ-003 Each operand channel SHALL have a one-deep holding slot with a full flag, where tready = !full.
REQ-004 An operand SHALL transfer at each edge with tvalid&&tready; the slot then captures tdata and sets full.
REQ-005 The two channels SHALL be independent: either operand may arrive first, and arrival gaps are unbounded.
REQ-006 The FSM SHALL have states IDLE, CALC and DONE.
REQ-007 In IDLE with both slots full, the next edge SHALL load the working registers, clear both full flags, zero the remainder and the iteration counter, and enter CALC.
REQ-008 CALC SHALL perform one restoring-division step per cycle (shift the remainder, trial-subtract, set one quotient bit, MSB first) for exactly DATA_W cycles, then enter DONE.
REQ-009 The remainder datapath SHALL be DATA_W+1 bits wide so that no step overflows.
REQ-010 Latency: if the last operand transfers at edge E, m_axis_dout_tvalid SHALL rise at edge E+DATA_W+1.
REQ-011 Latency SHALL be fixed and independent of the operand values.
REQ-012 In DONE, tvalid and tdata SHALL be held stable until the edge with m_axis_dout_tready=1; that edge clears tvalid and returns to IDLE.
REQ-013 Slots SHALL keep accepting new operands during CALC and DONE, giving one-deep prefetch.
REQ-014 With a prefetched pair, the cycle after the dout handshake SHALL load it, so the back-to-back period is DATA_W+2 cycles.
REQ-015 A divisor of 0 SHALL give quotient all-ones, the natural restoring result, with the same latency.
REQ-016 An operand handshake and a dout handshake on the same edge SHALL both take effect.
REQ-017 A full slot SHALL ignore tdata changes.

Reset
REQ-018 With s_aresetn=0 at an edge, the block SHALL set state IDLE, clear both full flags, set both tready outputs to 1 from the next cycle, and zero m_axis_dout_tvalid, tdata, tuser, the counter, the remainder and the quotient.
REQ-019 A reset during CALC or DONE SHALL abort the operation without emitting a result, and SHALL discard any prefetched operands.

Configuration
REQ-020 With the macro RSI_DIV_BYZERO_FLAG_EN defined, the block SHALL add the m_axis_dout_tuser port, equal to (captured divisor==0) and held with tdata.
REQ-021 Without the macro, the tuser port and its register SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-022 Package rsi_div_pkg SHALL hold the DATA_W default, the state enum (IDLE/CALC/DONE) and the counter width constant $clog2(DATA_W+1).
REQ-023 Sub-module rsi_div_operand_slot (holding register, full flag, tready) SHALL be instantiated twice, once for the dividend and once for the divisor.

Verification
REQ-024 Dividend 3700 and divisor 50 on the same cycle, tready held 1 -> quotient 74, with tvalid rising exactly 33 edges after the operand edge.
REQ-025 Dividend 100 and divisor 1, with the divisor sent 3 cycles after the dividend -> dividend_tready=0 until the load, then quotient 100 at 33 edges after the divisor edge.
REQ-026 Dividend 5 and divisor 0 -> quotient 0xFFFFFFFF; with RSI_DIV_BYZERO_FLAG_EN, tuser=1; for 5/5, quotient 1 and tuser=0.
REQ-027 Pair 3700/50, then m_axis_dout_tready=0 for 5 cycles while pair 900/30 is sent -> quotient 74 held stable; both tready=0 after prefetch; then 30 follows DATA_W+2 cycles after the first handshake.
REQ-028 s_aresetn=0 for 1 cycle at CALC iteration 10 -> no tvalid pulse; both tready=1 after reset; a new pair 81/9 -> quotient 9.
